// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: ALU control codes,
// FSM state encodings, divider iteration count and small arithmetic helpers.
package hilo_muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;

  // ALU control codes produced by the ALU decoder (only the ones acted on here
  // plus one ordinary ALU code used as a "no action" example).
  localparam logic [CTRL_W-1:0] ADD_CONTROL   = 5'b00010;
  localparam logic [CTRL_W-1:0] MULT_CONTROL  = 5'b10000;
  localparam logic [CTRL_W-1:0] MULTU_CONTROL = 5'b10001;
  localparam logic [CTRL_W-1:0] DIV_CONTROL   = 5'b10010;
  localparam logic [CTRL_W-1:0] DIVU_CONTROL  = 5'b10011;
  localparam logic [CTRL_W-1:0] MTHI_CONTROL  = 5'b10100;
  localparam logic [CTRL_W-1:0] MTLO_CONTROL  = 5'b10101;

  // Multiply/divide sequencer states.
  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MUL  = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // One quotient bit is produced per divider step.
  localparam logic [5:0] MD_DIV_ITERS = 6'd32;

  // Two's-complement negate when neg is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  // Magnitude of a signed value; 0x80000000 maps to itself, which is the
  // correct unsigned magnitude.
  function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] v);
    return neg_if(v, v[DATA_W-1]);
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// E-stage interface between the pipeline and the HI/LO multiply/divide unit.
interface hilo_muldiv_if;

  logic [hilo_muldiv_pkg::CTRL_W-1:0] alucontrol;
  logic                               valid_i;
  logic                               flush_i;
  logic [hilo_muldiv_pkg::DATA_W-1:0] src_a;
  logic [hilo_muldiv_pkg::DATA_W-1:0] src_b;
  logic                               stall_o;
  logic [hilo_muldiv_pkg::DATA_W-1:0] hi_o;
  logic [hilo_muldiv_pkg::DATA_W-1:0] lo_o;

  // Pipeline side: issues the E-stage instruction, observes stall and HI/LO.
  modport master (
    output alucontrol, valid_i, flush_i, src_a, src_b,
    input  stall_o, hi_o, lo_o
  );

  // Unit side.
  modport slave (
    input  alucontrol, valid_i, flush_i, src_a, src_b,
    output stall_o, hi_o, lo_o
  );

endinterface

// File: rtl/hilo_muldiv_div_radix2.sv
// Iterative unsigned restoring radix-2 divider core. A start pulse loads the
// operands; each following cycle performs one step. The next-state quotient
// and remainder are exposed so the parent can capture the final result in
// the same cycle the last step is computed (last_o high).
module div_radix2 import hilo_muldiv_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              abort_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] quo_next_o,
  output logic [DATA_W-1:0] rem_next_o,
  output logic              last_o
);

  logic [DATA_W-1:0] rem_q;
  logic [DATA_W-1:0] quo_q;   // holds the unconsumed dividend bits, shifted out MSB first
  logic [DATA_W-1:0] dvs_q;
  logic [5:0]        cnt_q;
  logic              busy_q;

  logic [DATA_W:0]   shifted_s;
  logic [DATA_W:0]   diff_s;
  logic              fits_s;

  // One restoring step: the borrow bit of the 33-bit trial subtract decides the quotient bit.
  always_comb begin
    shifted_s  = {rem_q, quo_q[DATA_W-1]};
    diff_s     = shifted_s - {1'b0, dvs_q};
    fits_s     = ~diff_s[DATA_W];
    rem_next_o = fits_s ? diff_s[DATA_W-1:0] : shifted_s[DATA_W-1:0];
    quo_next_o = {quo_q[DATA_W-2:0], fits_s};
    last_o     = busy_q & (cnt_q == (MD_DIV_ITERS - 6'd1));
  end

  // Shift register and iteration counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      cnt_q  <= 6'd0;
      busy_q <= 1'b0;
    end else if (abort_i) begin
      cnt_q  <= 6'd0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      rem_q  <= 32'd0;
      quo_q  <= dividend_i;
      dvs_q  <= divisor_i;
      cnt_q  <= 6'd0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q  <= rem_next_o;
      quo_q  <= quo_next_o;
      cnt_q  <= cnt_q + 6'd1;
      busy_q <= ~last_o;
    end else begin
      busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage multiply/divide unit owning the architectural HI/LO registers.
// The FSM sequences multi-cycle MULT/MULTU/DIV/DIVU and stalls the pipeline
// until the result is committed; MTHI/MTLO write directly from IDLE.
module hilo_muldiv import hilo_muldiv_pkg::*; (
  input  logic         clk,
  input  logic         rst,
  hilo_muldiv_if.slave bus
);

  md_state_e           state_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic                mul_signed_q;
  logic                q_neg_q;
  logic                r_neg_q;
  logic                wr_en_q;
  logic [2*DATA_W-1:0] result_q;

  logic                is_mul_s;
  logic                is_div_s;
  logic                is_mt_s;
  logic                sdiv_s;
  logic                start_s;
  logic                mt_s;
  logic                div_zero_s;
  logic                div_start_s;
  logic [DATA_W-1:0]   dividend_s;
  logic [DATA_W-1:0]   divisor_s;
  logic [2*DATA_W-1:0] opa_ext_s;
  logic [2*DATA_W-1:0] opb_ext_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [DATA_W-1:0]   quo_next_s;
  logic [DATA_W-1:0]   rem_next_s;
  logic                div_last_s;

  // Decode, start/stall generation, divider operand magnitudes and the multiplier.
  always_comb begin
    is_mul_s    = (bus.alucontrol == MULT_CONTROL) || (bus.alucontrol == MULTU_CONTROL);
    is_div_s    = (bus.alucontrol == DIV_CONTROL)  || (bus.alucontrol == DIVU_CONTROL);
    is_mt_s     = (bus.alucontrol == MTHI_CONTROL) || (bus.alucontrol == MTLO_CONTROL);
    sdiv_s      = (bus.alucontrol == DIV_CONTROL);
    start_s     = bus.valid_i & ~bus.flush_i & (state_q == MD_IDLE) & (is_mul_s | is_div_s);
    mt_s        = bus.valid_i & ~bus.flush_i & (state_q == MD_IDLE) & is_mt_s;
    div_zero_s  = (bus.src_b == 32'd0);
    div_start_s = start_s & is_div_s & ~div_zero_s;
    dividend_s  = sdiv_s ? abs32(bus.src_a) : bus.src_a;
    divisor_s   = sdiv_s ? abs32(bus.src_b) : bus.src_b;
    // Sign-extending to 64 bits and keeping the low 64 product bits yields
    // the exact signed product; zero-extension gives the unsigned one.
    opa_ext_s   = {{DATA_W{mul_signed_q & a_q[DATA_W-1]}}, a_q};
    opb_ext_s   = {{DATA_W{mul_signed_q & b_q[DATA_W-1]}}, b_q};
    prod_s      = opa_ext_s * opb_ext_s;
    // Reset is included so the stall drops the moment reset asserts,
    // even while a mul/div instruction is still presented.
    bus.stall_o = ~rst & ~bus.flush_i &
                  (start_s | (state_q == MD_MUL) | (state_q == MD_DIV));
  end

  assign bus.hi_o = hi_q;
  assign bus.lo_o = lo_q;

  div_radix2 u_div (
    .clk        (clk),
    .rst        (rst),
    .abort_i    (bus.flush_i),
    .start_i    (div_start_s),
    .dividend_i (dividend_s),
    .divisor_i  (divisor_s),
    .quo_next_o (quo_next_s),
    .rem_next_o (rem_next_s),
    .last_o     (div_last_s)
  );

  // Sequencer FSM with operand latches, result register and HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MD_IDLE;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      result_q     <= 64'd0;
    end else if (bus.flush_i) begin
      state_q <= MD_IDLE;
      wr_en_q <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (start_s) begin
            if (is_mul_s) begin
              a_q          <= bus.src_a;
              b_q          <= bus.src_b;
              mul_signed_q <= (bus.alucontrol == MULT_CONTROL);
              state_q      <= MD_MUL;
            end else if (div_zero_s) begin
              wr_en_q <= 1'b0;
              state_q <= MD_DONE;
            end else begin
              q_neg_q <= sdiv_s & (bus.src_a[DATA_W-1] ^ bus.src_b[DATA_W-1]);
              r_neg_q <= sdiv_s & bus.src_a[DATA_W-1];
              state_q <= MD_DIV;
            end
          end else if (mt_s) begin
            if (bus.alucontrol == MTHI_CONTROL) begin
              hi_q <= bus.src_a;
            end else begin
              lo_q <= bus.src_a;
            end
          end else begin
            state_q <= MD_IDLE;
          end
        end
        MD_MUL: begin
          result_q <= prod_s;
          wr_en_q  <= 1'b1;
          state_q  <= MD_DONE;
        end
        MD_DIV: begin
          if (div_last_s) begin
            result_q <= {neg_if(rem_next_s, r_neg_q), neg_if(quo_next_s, q_neg_q)};
            wr_en_q  <= 1'b1;
            state_q  <= MD_DONE;
          end else begin
            state_q <= MD_DIV;
          end
        end
        MD_DONE: begin
          if (wr_en_q) begin
            hi_q <= result_q[2*DATA_W-1:DATA_W];
            lo_q <= result_q[DATA_W-1:0];
          end else begin
            hi_q <= hi_q;
          end
          wr_en_q <= 1'b0;
          state_q <= MD_IDLE;
        end
        default: begin
          wr_en_q <= 1'b0;
          state_q <= MD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Scoreboard bench for hilo_muldiv: each mul/div pushes its expected HI/LO and
// stall length; a monitor measures each stall run and checks the result one
// cycle after the run ends.
module tb_hilo_muldiv;
  import hilo_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst;

  hilo_muldiv_if bus ();

  hilo_muldiv dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   run_len  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.valid_i    = 1'b0;
    bus.flush_i    = 1'b0;
    bus.alucontrol = ADD_CONTROL;
    bus.src_a      = 32'd0;
    bus.src_b      = 32'd0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.valid_i    = 1'b1;
    bus.flush_i    = 1'b0;
    bus.alucontrol = op;
    bus.src_a      = a;
    bus.src_b      = b;
  endtask

  // Full mul/div: instruction held while stalled and through DONE.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int est,
                       input string name);
    int guard;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.stalls = est; e.name = name;
    sb.push_back(e);
    @(posedge clk); #1;
    drive(op, a, b);
    guard = 0;
    do begin
      @(posedge clk); #1;
      guard++;
    end while (bus.stall_o && guard < 100);
    if (guard >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s timeout: stall_o still 1 after %0d cycles, required 0", name, guard);
    end
    @(posedge clk); #1;
    idle();
    @(posedge clk); #1;
  endtask

  // Single-cycle MTHI/MTLO (optionally presented with flush).
  task automatic mt(input logic [4:0] op, input logic [31:0] d, input logic fl);
    @(posedge clk); #1;
    drive(op, d, 32'd0);
    bus.flush_i = fl;
    @(posedge clk); #1;
    idle();
  endtask

  // Monitor: measure each stall run, then check HI/LO the cycle after DONE.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.stall_o === 1'b1) begin
        run_len++;
      end else if (run_len > 0) begin
        @(negedge clk);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_stall: got stall run of %0d cycles, expected none", run_len);
        end else begin
          e = sb.pop_front();
          check32({e.name, " stall_cycles"}, 32'(run_len), 32'(e.stalls));
          check32({e.name, " hi"}, bus.hi_o, e.hi);
          check32({e.name, " lo"}, bus.lo_o, e.lo);
        end
        run_len = 0;
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1;
    check32("reset hi", bus.hi_o, 32'h0000_0000);
    check32("reset lo", bus.lo_o, 32'h0000_0000);
    check32("reset stall", 32'(bus.stall_o), 32'd0);
    rst = 1'b0;

    // Multiplies.
    issue(MULT_CONTROL,  32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, "mult");
    issue(MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 2, "multu");

    // Divides.
    issue(DIV_CONTROL,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, "div_neg7_2");
    issue(DIVU_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 33, "divu");
    issue(DIV_CONTROL,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33, "div_min");

    // MTHI/MTLO preload, a flushed MTLO and an unrelated ALU op.
    mt(MTHI_CONTROL, 32'h1111_1111, 1'b0);
    check32("mthi", bus.hi_o, 32'h1111_1111);
    mt(MTLO_CONTROL, 32'h2222_2222, 1'b0);
    check32("mtlo", bus.lo_o, 32'h2222_2222);
    mt(MTLO_CONTROL, 32'hDEAD_BEEF, 1'b1);
    check32("mtlo_flushed", bus.lo_o, 32'h2222_2222);
    @(posedge clk); #1;
    drive(ADD_CONTROL, 32'h5555_5555, 32'hAAAA_AAAA);
    check32("other_op stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    idle();
    check32("other_op hi", bus.hi_o, 32'h1111_1111);

    // Divide by zero: one stall cycle, no write.
    issue(DIV_CONTROL, 32'd5, 32'd0, 32'h1111_1111, 32'h2222_2222, 1, "div_by_zero");

    // Flush at iteration 10 of a divide, then MTHI.
    e.hi = 32'h1111_1111; e.lo = 32'h2222_2222; e.stalls = 11; e.name = "div_flush";
    sb.push_back(e);
    @(posedge clk); #1;
    drive(DIV_CONTROL, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;
    bus.flush_i = 1'b1;
    #1;
    check32("flush stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1;
    drive(MTHI_CONTROL, 32'h1234_5678, 32'd0);
    check32("post_flush stall", 32'(bus.stall_o), 32'd0);
    check32("post_flush hi", bus.hi_o, 32'h1111_1111);
    @(posedge clk); #1;
    idle();
    check32("mthi_after_flush hi", bus.hi_o, 32'h1234_5678);
    check32("mthi_after_flush lo", bus.lo_o, 32'h2222_2222);

    // Full divide after an aborted one: 100/7 = 14 rem 2.
    issue(DIVU_CONTROL, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 33, "divu_after_flush");

    // Asynchronous reset during iteration 20 of a divide.
    e.hi = 32'h0; e.lo = 32'h0; e.stalls = 21; e.name = "div_reset";
    sb.push_back(e);
    @(posedge clk); #1;
    drive(DIV_CONTROL, 32'd100, 32'd7);
    repeat (21) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check32("async_reset hi", bus.hi_o, 32'h0000_0000);
    check32("async_reset lo", bus.lo_o, 32'h0000_0000);
    check32("async_reset stall", 32'(bus.stall_o), 32'd0);
    idle();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    issue(MULTU_CONTROL, 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C, 2, "multu_after_reset");

    repeat (4) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
